pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register with a valid/ready handshake, flush and bubble insertion.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_skid_buf.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 161 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control field map, per-stage payload widths, stage states.
// Optional skid buffer in pipe_stage_reg is enabled by the PIPE_STAGE_SKID_EN macro.
package pipe_pkg;

  localparam int CTRL_W         = 8;
  localparam int CTRL_ALUSRC    = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_REGWRITE  = 2;
  localparam int CTRL_MEMREAD   = 3;
  localparam int CTRL_MEMWRITE  = 4;
  localparam int CTRL_BRANCH    = 5;
  localparam int CTRL_ALUOP_LSB = 6;
  localparam int CTRL_ALUOP_MSB = 7;

  // IF/ID: PC + instruction
  localparam int IFID_W  = 64 + 32;
  // ID/EX: RD1, RD2, Imm, PC, WriteReg, Opcode
  localparam int IDEX_W  = 4 * 64 + 5 + 11;
  // EX/MEM: branch target, ALU result, store data, zero, WriteReg
  localparam int EXMEM_W = 3 * 64 + 1 + 5;
  // MEM/WB: load data, ALU result, WriteReg
  localparam int MEMWB_W = 2 * 64 + 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry data+ctrl holding register parked behind a stalled stage output.
// Used by pipe_stage_reg only when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] inData,
  input  logic [CTRL_W-1:0] inCtrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Occupancy flag: clear wins, then load, then unload.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

  // Payload captured on load, kept otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      ctrl <= '0;
    end else if (load) begin
      data <= inData;
      ctrl <= inCtrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, flush, bubble control-zeroing and stall counter.
// Define PIPE_STAGE_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = IDEX_W,
  parameter int CTRL_W      = pipe_pkg::CTRL_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  pipe_state_e state;
  pipe_state_e stateNext;

  logic outValid;
  logic accept;
  logic retire;
  logic loadIn;
  logic loadSkid;

  logic [DATA_W-1:0] dataReg;
  logic [CTRL_W-1:0] ctrlReg;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;

  logic [STALL_CNT_W-1:0] stallCnt;

  assign outValid = (state != EMPTY);
  assign accept   = in_valid & in_ready;
  assign retire   = outValid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic skidValid;
  logic skidLoad;
  logic skidUnload;

  assign in_ready = !rst & !skidValid;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) uSkid (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .load   (skidLoad),
    .unload (skidUnload),
    .inData (in_data),
    .inCtrl (in_ctrl),
    .valid  (skidValid),
    .data   (skidData),
    .ctrl   (skidCtrl)
  );
`else
  assign in_ready = !rst & (!outValid | out_ready);
  assign skidData = '0;
  assign skidCtrl = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and load strobes; flush overrides everything.
  always_comb begin
    stateNext = state;
    loadIn    = 1'b0;
    loadSkid  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skidLoad   = 1'b0;
    skidUnload = 1'b0;
`endif
    unique case (state)
      EMPTY: begin
        if (accept) begin
          stateNext = FULL;
          loadIn    = 1'b1;
        end
      end
      FULL: begin
        if (accept && retire) begin
          loadIn = 1'b1;
        end else if (retire) begin
          stateNext = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
        end else if (accept) begin
          stateNext = SKID;
          skidLoad  = 1'b1;
`endif
        end
      end
      SKID: begin
        if (retire) begin
          stateNext = FULL;
          loadSkid  = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          skidUnload = 1'b1;
`endif
        end
      end
      default: stateNext = EMPTY;
    endcase
    if (flush) begin
      stateNext = EMPTY;
      loadIn    = 1'b0;
      loadSkid  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skidLoad   = 1'b0;
      skidUnload = 1'b0;
`endif
    end
  end

  // Output payload: new beat from input or from the skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataReg <= '0;
      ctrlReg <= '0;
    end else if (loadIn) begin
      dataReg <= in_data;
      ctrlReg <= in_ctrl;
    end else if (loadSkid) begin
      dataReg <= skidData;
      ctrlReg <= skidCtrl;
    end
  end

  // Saturating count of stalled output cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (outValid && !out_ready && !flush) begin
      if (stallCnt != '1) begin
        stallCnt <= stallCnt + 1'b1;
      end
    end
  end

  assign out_valid    = outValid;
  assign out_data     = dataReg;
  assign out_ctrl     = outValid ? ctrlReg : '0;
  assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
// Honours PIPE_STAGE_SKID_EN to pick the stage capacity of the model.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int SW = 4;
  localparam int STALL_MAX = (1 << SW) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [SW-1:0] stall_cycles;

  pipe_stage_reg #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .STALL_CNT_W (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t         q[$];
  int            expStall = 0;
  logic [DW-1:0] lastOut  = '0;

  logic          pendValid = 1'b0;
  logic [DW-1:0] pendData  = '0;
  logic [CW-1:0] pendCtrl  = '0;

  int nChecks = 0;
  int nFails  = 0;
  int validSeen = 0;

  task automatic checkEq(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
    pendValid = 1'b1;
    pendData  = d;
    pendCtrl  = c;
  endtask

  // One clock: drive, check against the model, advance the model.
  task automatic cycle(input logic ordy, input logic fl, input logic r);
    logic expRdy;
    logic acc;
    @(negedge clk);
    rst       = r;
    flush     = fl;
    out_ready = ordy;
    in_valid  = pendValid;
    in_data   = pendData;
    in_ctrl   = pendCtrl;
    #1;
    if (r) expRdy = 1'b0;
    else if (SKID) expRdy = (q.size() < 2);
    else expRdy = (q.size() == 0) || ordy;
    checkEq("in_ready", in_ready, expRdy);
    checkEq("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      lastOut = q[0].d;
      checkEq("out_ctrl", out_ctrl, q[0].c);
      validSeen++;
    end else begin
      checkEq("out_ctrl_bubble", out_ctrl, 0);
    end
    checkEq("out_data", out_data, lastOut);
    checkEq("stall_cycles", stall_cycles, expStall);
    acc = pendValid & expRdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      expStall = 0;
      lastOut  = '0;
    end else begin
      if (q.size() != 0 && !ordy && !fl && expStall < STALL_MAX)
        expStall++;
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (acc) q.push_back('{pendData, pendCtrl});
      end
    end
    if (acc) pendValid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;

    // Reset with a beat already offered.
    offer(16'h0001, 8'h11);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    checkEq("first_accept", pendValid, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    // Streaming 8 beats.
    validSeen = 0;
    for (int i = 1; i <= 8; i++) begin
      offer(DW'(i), 8'hA5);
      cycle(1'b1, 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    checkEq("stream_valid_cycles", validSeen, 8);

    // Back-pressure with a second beat waiting.
    cycle(1'b1, 1'b0, 1'b1);
    offer(16'h0055, 8'h3C);
    cycle(1'b0, 1'b0, 1'b0);
    offer(16'h0066, 8'hC3);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
    #1;
    checkEq("stall5", stall_cycles, 5);
    checkEq("hold55", out_data, 16'h0055);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    checkEq("beat66_taken", pendValid, 1'b0);

    // Flush while FULL with a concurrent handshake.
    offer(16'h0100, 8'h0F);
    cycle(1'b0, 1'b0, 1'b0);
    offer(16'h0101, 8'hF0);
    cycle(1'b1, 1'b1, 1'b0);
    #1;
    checkEq("flush_full_valid", out_valid, 1'b0);
    checkEq("flush_full_ctrl", out_ctrl, 0);
    pendValid = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);

    // Flush with the stage stalled (SKID when enabled).
    offer(16'h0200, 8'h21);
    cycle(1'b0, 1'b0, 1'b0);
    offer(16'h0201, 8'h22);
    cycle(1'b0, 1'b0, 1'b0);
    offer(16'h0202, 8'h23);
    cycle(1'b0, 1'b1, 1'b0);
    #1;
    checkEq("flush_stall_valid", out_valid, 1'b0);
    checkEq("flush_stall_ctrl", out_ctrl, 0);
    pendValid = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    // Bubble after a beat with all control bits set.
    offer(16'h0077, 8'hFF);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        checkEq("bubble_ctrl", out_ctrl, 0);
        checkEq("bubble_data", out_data, 16'h0077);
      end
    end

    // Counter saturation.
    cycle(1'b1, 1'b0, 1'b1);
    offer(16'h0099, 8'h01);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
    #1;
    checkEq("stall_sat", stall_cycles, STALL_MAX);
    pendValid = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (!pendValid && $urandom_range(0, 3) != 0)
        offer(DW'($urandom), CW'($urandom));
      cycle($urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
